// File: rtl/temporal_encoder.sv
// temporal_encoder
// Converts a binary value into a pulse-width-coded temporal event on y, once
// per gamma cycle. Values arrive over valid/ready into a one-entry holding
// register. At gamma_start the value moves into the active slot, and y goes
// high after that many aclk cycles.
// Optional feature: define ENCODER_RISING_EN for rising-edge coding. In that
// mode y stays high from the event time until the next gamma_start or grst.
module temporal_encoder #(
    parameter int  GAMMA_CYCLE_WIDTH = 16,
    parameter int  PULSE_WIDTH       = 8,
    localparam int VW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          gamma_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_data,
    output logic          y,
    output logic          busy,
    output logic          abort
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PULSE,
        S_DONE
    } state_t;

`ifndef ENCODER_RISING_EN
    localparam int             PCW     = $clog2(PULSE_WIDTH + 1);
    localparam logic [VW-1:0]  MAXV    = VW'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);
    localparam logic [PCW-1:0] PW_LAST = PCW'(PULSE_WIDTH);
`endif

    state_t          state_q, state_d;
    logic            hold_valid_q, hold_valid_d;
    logic [VW-1:0]   hold_data_q, hold_data_d;
    logic [VW-1:0]   value_q, value_d;
    logic [VW-1:0]   phase_q, phase_d;
`ifndef ENCODER_RISING_EN
    logic [PCW-1:0]  pcnt_q, pcnt_d;
`endif
    logic            y_q, y_d;
    logic            busy_q, busy_d;
    logic            abort_q, abort_d;

    logic            accept;
    logic            sched_valid;
    logic [VW-1:0]   sched_value;
    logic            sched_null;
    logic            unfinished;

    // The holding register is the only source of backpressure, so in_ready
    // does not depend on in_valid.
    assign in_ready = !hold_valid_q;
    assign y        = y_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

    // Pick the value that a gamma_start in this cycle would schedule, and
    // decide whether the current event would be cut short.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no latch can form.
        accept      = in_valid && !hold_valid_q;
        sched_valid = 1'b0;
        sched_value = in_data;
        if (hold_valid_q) begin
            sched_valid = 1'b1;
            sched_value = hold_data_q;
        end else if (accept) begin
            sched_valid = 1'b1;
            sched_value = in_data;
        end
`ifdef ENCODER_RISING_EN
        // Every VW-bit value fits inside the gamma cycle.
        sched_null = !sched_valid;
        // The event is unfinished only while the rising edge is still pending.
        unfinished = (state_q == S_WAIT);
`else
        sched_null = !sched_valid || (sched_value > MAXV);
        // The last PULSE cycle completes the event, so a restart there is not a truncation.
        unfinished = (state_q == S_WAIT) ||
                     ((state_q == S_PULSE) && (pcnt_q != PW_LAST));
`endif
    end

    // Next-state logic for the holding register, the scheduler FSM and its
    // registered outputs.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        value_d      = value_q;
        phase_d      = phase_q;
`ifndef ENCODER_RISING_EN
        pcnt_d       = pcnt_q;
`endif
        y_d          = y_q;
        busy_d       = busy_q;
        abort_d      = 1'b0;

        if (gamma_start) begin
            // Restart scheduling from phase 0 in any state.
            abort_d = unfinished;
            // Draining the hold takes priority. A word offered in the same
            // cycle was not accepted, because in_ready was low. When the hold
            // is empty, an accepted word bypasses it and goes straight to the
            // active slot.
            hold_valid_d = 1'b0;
            value_d      = sched_value;
            phase_d      = VW'(1);
            if (sched_null) begin
                state_d = S_DONE;
                y_d     = 1'b0;
                busy_d  = 1'b0;
            end else if (sched_value == '0) begin
                state_d = S_PULSE;
                y_d     = 1'b1;
                busy_d  = 1'b1;
`ifndef ENCODER_RISING_EN
                pcnt_d  = PCW'(1);
`endif
            end else begin
                state_d = S_WAIT;
                y_d     = 1'b0;
                busy_d  = 1'b1;
            end
        end else begin
            if (accept) begin
                hold_valid_d = 1'b1;
                hold_data_d  = in_data;
            end
            case (state_q)
                S_WAIT: begin
                    // The phase counter holds the phase of the current cycle.
                    // y rises in the cycle after the phase counter matches the value.
                    if (phase_q == value_q) begin
                        state_d = S_PULSE;
                        y_d     = 1'b1;
`ifndef ENCODER_RISING_EN
                        pcnt_d  = PCW'(1);
`endif
                    end else begin
                        phase_d = phase_q + VW'(1);
                    end
                end
                S_PULSE: begin
`ifndef ENCODER_RISING_EN
                    if (pcnt_q == PW_LAST) begin
                        state_d = S_DONE;
                        y_d     = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + PCW'(1);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Register control state with synchronous reset; datapath registers follow *_d unconditionally.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (grst) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            y_q          <= 1'b0;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            abort_q      <= abort_d;
        end
        // NOTE: datapath registers have no reset. Their contents are used only behind hold_valid_q or state_q.
        hold_data_q <= hold_data_d;
        value_q     <= value_d;
        phase_q     <= phase_d;
`ifndef ENCODER_RISING_EN
        pcnt_q      <= pcnt_d;
`endif
    end

endmodule
